// File: rtl/if_id_stage_buffer.sv
// -----------------------------------------------------------------------------
// if_id_stage_buffer
//   IF/ID pipeline register with a small in-order skid FIFO that absorbs
//   instruction-bus responses returning while decode is stalled. Tracks
//   outstanding fetches to throttle IF, and discards responses that belong
//   to requests issued before a flush.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   IF_ID_reg_stall    hold the ID register (hazard detection)
//   flush              squash ID and every fetched-not-decoded instruction
//   inst_req_fire      a fetch address was accepted by the bus this cycle
//   inst_data_ok       fetch response valid this cycle
//   inst_rdata/pc_resp response instruction word and its PC
//   can_issue          IF may issue a new fetch this cycle
//   valid_ID/pc_ID/inst_ID  decode-stage instruction
//   buf_count          skid FIFO occupancy
//
// Optional feature (macro IF_ID_PERF_EN):
//   perf_stall_cycles  cycles with a live ID instruction held by a stall
//   perf_bubble_cycles cycles in which ID loads a bubble
// -----------------------------------------------------------------------------
module if_id_stage_buffer #(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             IF_ID_reg_stall,
  input  logic             flush,
  input  logic             inst_req_fire,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  input  logic [31:0]      pc_resp,
  output logic             can_issue,
  output logic             valid_ID,
  output logic [31:0]      pc_ID,
  output logic [31:0]      inst_ID,
  output logic [CNT_W:0]   buf_count
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_bubble_cycles
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W:0]   r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic             r_valid;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;

  logic             w_live;
  logic             w_fifo_empty;
  logic             w_load_ok;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W+1:0] w_inflight;

  // A response is kept only if no stale responses are still owed and no
  // flush is squashing the pipe this cycle.
  assign w_live       = inst_data_ok && (r_discard == '0) && !flush;
  assign w_fifo_empty = (r_count == '0);
  assign w_load_ok    = !flush && !IF_ID_reg_stall;
  assign w_pop        = w_load_ok && !w_fifo_empty;
  // Bypass straight into ID only when the FIFO is empty; otherwise queue
  // behind older entries to keep program order.
  assign w_push       = w_live && (IF_ID_reg_stall || !w_fifo_empty);

  // Counting buffered plus in-flight fetches reserves a FIFO slot for every
  // response that could come back live.
  assign w_inflight = {2'b00, r_outstanding} + {1'b0, r_count};
  assign can_issue  = w_inflight < (CNT_W+2)'(BUF_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Outstanding / discard bookkeeping
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(inst_req_fire) - CNT_W'(inst_data_ok);
      if (flush) begin
        // Everything outstanding before this edge is stale, minus the
        // response consumed now; a fire in this cycle is already redirected.
        r_discard <= r_outstanding - CNT_W'(inst_data_ok);
      end else if (inst_data_ok && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and
  // count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: pc_resp, inst: inst_rdata};
  end

  // ID register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!IF_ID_reg_stall) begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_pc    <= r_mem[r_rd_ptr].pc;
        r_inst  <= r_mem[r_rd_ptr].inst;
      end else if (w_live) begin
        r_valid <= 1'b1;
        r_pc    <= pc_resp;
        r_inst  <= inst_rdata;
      end else begin
        // Bubble: payload holds its last value, only valid drops.
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_ID  = r_valid;
  assign pc_ID     = r_pc;
  assign inst_ID   = r_inst;
  assign buf_count = r_count;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_stall  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (r_valid && IF_ID_reg_stall && !flush) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_load_ok && w_fifo_empty && !w_live) r_perf_bubble <= r_perf_bubble + 1'b1;
    end
  end

  assign perf_stall_cycles  = r_perf_stall;
  assign perf_bubble_cycles = r_perf_bubble;
`endif

  // Overflow is impossible while IF honours can_issue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(w_push && !w_pop && (r_count == (CNT_W+1)'(BUF_DEPTH))));

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_data_ok && (r_outstanding == '0)));

endmodule

// File: tb/tb_if_id_stage_buffer.sv
module tb_if_id_stage_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk;
  logic          resetn;
  logic          IF_ID_reg_stall;
  logic          flush;
  logic          inst_req_fire;
  logic          inst_data_ok;
  logic [31:0]   inst_rdata;
  logic [31:0]   pc_resp;
  logic          can_issue;
  logic          valid_ID;
  logic [31:0]   pc_ID;
  logic [31:0]   inst_ID;
  logic [CW:0]   buf_count;
`ifdef IF_ID_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_bubble_cycles;
`endif

  if_id_stage_buffer #(.BUF_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .IF_ID_reg_stall    (IF_ID_reg_stall),
    .flush              (flush),
    .inst_req_fire      (inst_req_fire),
    .inst_data_ok       (inst_data_ok),
    .inst_rdata         (inst_rdata),
    .pc_resp            (pc_resp),
    .can_issue          (can_issue),
    .valid_ID           (valid_ID),
    .pc_ID              (pc_ID),
    .inst_ID            (inst_ID),
    .buf_count          (buf_count)
`ifdef IF_ID_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_bubble_cycles (perf_bubble_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: counts, a queue for the skid buffer, and the
  // bus's own queue of requests awaiting a response.
  logic [31:0] bus_q[$];
  logic [63:0] m_fifo[$];
  int          m_out, m_disc;
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  int          m_perf_stall, m_perf_bubble;

  typedef struct {
    logic        stall;
    logic        fl;
    logic        fire;
    logic [31:0] fire_pc;
    logic        ok;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [CW:0] exp_cnt;
    logic        exp_ci;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    bus_q.delete();
    m_out = 0; m_disc = 0;
    m_valid = 1'b0; m_pc = '0; m_inst = '0;
    m_perf_stall = 0; m_perf_bubble = 0;
  endtask

  function automatic bit m_can_issue();
    return (m_out + m_fifo.size()) < DEPTH;
  endfunction

  task automatic model_update(input logic stall, input logic fl, input logic fire,
                              input logic ok, input logic [31:0] rpc);
    logic        live;
    logic [63:0] e;
    live = ok && (m_disc == 0) && !fl;
    if (!fl && stall && m_valid) m_perf_stall++;
    if (fl) begin
      m_valid = 1'b0;
      m_fifo.delete();
      m_disc = m_out - int'(ok);
    end else begin
      if (ok && m_disc > 0) m_disc--;
      if (stall) begin
        if (live) m_fifo.push_back({rpc, inst_of(rpc)});
      end else if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_valid = 1'b1; m_pc = e[63:32]; m_inst = e[31:0];
        if (live) m_fifo.push_back({rpc, inst_of(rpc)});
      end else if (live) begin
        m_valid = 1'b1; m_pc = rpc; m_inst = inst_of(rpc);
      end else begin
        m_valid = 1'b0;
        m_perf_bubble++;
      end
    end
    m_out = m_out + int'(fire) - int'(ok);
  endtask

  // One clock: drive inputs right after an edge, advance past the next edge,
  // update the model and compare every output against it.
  task automatic step(input logic stall, input logic fl, input logic fire,
                      input logic [31:0] fire_pc, input logic ok_req);
    logic        ok;
    logic [31:0] rpc;
    ok  = ok_req && (bus_q.size() > 0);
    rpc = '0;
    if (ok) rpc = bus_q.pop_front();
    if (fire) bus_q.push_back(fire_pc);
    IF_ID_reg_stall = stall;
    flush           = fl;
    inst_req_fire   = fire;
    inst_data_ok    = ok;
    pc_resp         = rpc;
    inst_rdata      = inst_of(rpc);
    @(posedge clk);
    #1;
    model_update(stall, fl, fire, ok, rpc);
    check("valid_ID",  {31'b0, valid_ID},  {31'b0, m_valid});
    check("pc_ID",     pc_ID,              m_pc);
    check("inst_ID",   inst_ID,            m_inst);
    check("buf_count", 32'(buf_count),     32'(m_fifo.size()));
    check("can_issue", {31'b0, can_issue}, {31'b0, m_can_issue()});
`ifdef IF_ID_PERF_EN
    check("perf_stall",  perf_stall_cycles,  32'(m_perf_stall));
    check("perf_bubble", perf_bubble_cycles, 32'(m_perf_bubble));
`endif
  endtask

  initial begin
    resetn = 1'b0; IF_ID_reg_stall = 1'b0; flush = 1'b0;
    inst_req_fire = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; pc_resp = '0;
    model_reset();

    // Streaming: fire each cycle, response one cycle later.
    vecs[0] = '{stall:0, fl:0, fire:1, fire_pc:32'h0, ok:0, exp_valid:0, exp_pc:32'h0, exp_cnt:0, exp_ci:1};
    vecs[1] = '{stall:0, fl:0, fire:1, fire_pc:32'h4, ok:1, exp_valid:1, exp_pc:32'h0, exp_cnt:0, exp_ci:1};
    vecs[2] = '{stall:0, fl:0, fire:1, fire_pc:32'h8, ok:1, exp_valid:1, exp_pc:32'h4, exp_cnt:0, exp_ci:1};
    vecs[3] = '{stall:0, fl:0, fire:0, fire_pc:32'h0, ok:1, exp_valid:1, exp_pc:32'h8, exp_cnt:0, exp_ci:1};
    vecs[4] = '{stall:0, fl:0, fire:0, fire_pc:32'h0, ok:0, exp_valid:0, exp_pc:32'h8, exp_cnt:0, exp_ci:1};

    #12;
    check("rst valid_ID",  {31'b0, valid_ID},  32'h0);
    check("rst pc_ID",     pc_ID,              32'h0);
    check("rst inst_ID",   inst_ID,            32'h0);
    check("rst buf_count", 32'(buf_count),     32'h0);
    check("rst can_issue", {31'b0, can_issue}, 32'h1);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      step(vecs[i].stall, vecs[i].fl, vecs[i].fire, vecs[i].fire_pc, vecs[i].ok);
      check($sformatf("vec%0d valid", i), {31'b0, valid_ID},  {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d pc", i),    pc_ID,              vecs[i].exp_pc);
      check($sformatf("vec%0d cnt", i),   32'(buf_count),     32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d ci", i),    {31'b0, can_issue}, {31'b0, vecs[i].exp_ci});
    end

    // Stall absorb: two responses arrive under a 3-cycle stall.
    step(0, 0, 1, 32'h10, 0);
    step(0, 0, 1, 32'h14, 0);
    check("absorb ci pre", {31'b0, can_issue}, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);
    check("absorb cnt",  32'(buf_count),     32'h2);
    check("absorb ci",   {31'b0, can_issue}, 32'h0);
    check("absorb hold", pc_ID,              32'h8);
    step(0, 0, 0, 32'h0, 0);
    check("absorb pop0", pc_ID, 32'h10);
    step(0, 0, 0, 32'h0, 0);
    check("absorb pop1", pc_ID, 32'h14);
    check("absorb empty", 32'(buf_count), 32'h0);

    // Flush with two outstanding, no fire.
    step(0, 0, 1, 32'h40, 0);
    step(0, 0, 1, 32'h44, 0);
    step(0, 1, 0, 32'h0, 0);
    check("flush2 valid", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("flush2 drop0", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 1, 32'h80, 1);
    check("flush2 drop1", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("flush2 live", pc_ID,   32'h80);
    check("flush2 inst", inst_ID, inst_of(32'h80));

    // Flush with simultaneous data_ok and fire.
    step(0, 0, 1, 32'h50, 0);
    step(0, 0, 1, 32'h54, 0);
    step(0, 1, 1, 32'h90, 1);
    check("flushok valid", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("flushok drop", {31'b0, valid_ID}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    check("flushok live", pc_ID, 32'h90);
    check("flushok vld",  {31'b0, valid_ID}, 32'h1);

    // Reset in the middle of a stall with a full FIFO.
    step(0, 0, 1, 32'h20, 0);
    step(0, 0, 1, 32'h24, 0);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    check("prerst cnt", 32'(buf_count), 32'h2);
    resetn = 1'b0;
    #2;
    check("midrst valid", {31'b0, valid_ID},  32'h0);
    check("midrst pc",    pc_ID,              32'h0);
    check("midrst inst",  inst_ID,            32'h0);
    check("midrst cnt",   32'(buf_count),     32'h0);
    check("midrst ci",    {31'b0, can_issue}, 32'h1);
    model_reset();
    IF_ID_reg_stall = 1'b0; inst_data_ok = 1'b0; inst_req_fire = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      logic st, fl, fi, ok;
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 15) == 0);
      fi = m_can_issue() && ($urandom_range(0, 1) == 1);
      ok = (bus_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(st, fl, fi, $urandom & 32'hFFFF_FFFC, ok);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage_buffer.md
Name: if_id_stage_buffer

Overview:
- Sits between instruction fetch (IF) and decode (ID); owns the IF/ID pipeline register.
- Consumes IF_ID_reg_stall from ID hazard detection and the branch/exception flush.
- Absorbs instruction-bus responses that return while ID is stalled in a small FIFO.
- Tracks outstanding fetches, throttles new fetches, and discards responses belonging to flushed requests.

Parameters:
BUF_DEPTH, 2, skid FIFO entries and maximum in-flight plus buffered fetches; power of two, >=1
CNT_W, 2, width of outstanding/discard/occupancy counters; must hold BUF_DEPTH

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
IF_ID_reg_stall  input  1  hold ID register (from hazard detection)
flush  input  1  squash ID and all fetched-not-decoded instructions
inst_req_fire  input  1  IF fetch address accepted by bus this cycle
inst_data_ok  input  1  fetch response valid this cycle
inst_rdata  input  32  fetched instruction
pc_resp  input  32  PC of the response, aligned with inst_data_ok
can_issue  output  1  IF may issue a new fetch this cycle
valid_ID  output  1  ID holds a live instruction
pc_ID  output  32  PC of ID instruction
inst_ID  output  32  ID instruction word
buf_count  output  CNT_W+1  FIFO occupancy

Behaviour:
- One clock; reset is asynchronous and active-low (resetn).
- Reset values: valid_ID=0, pc_ID=0, inst_ID=0, FIFO empty, buf_count=0, outstanding=0, discard=0, can_issue=1.
- Combinational can_issue = (outstanding + buf_count) < BUF_DEPTH. This guarantees FIFO room for every live response.
- outstanding counter:
  - +1 on inst_req_fire; -1 on inst_data_ok; both in one cycle leave it unchanged.
  - Its value is independent of flush; discarded responses still decrement it.
- A response is "live" when inst_data_ok=1, discard==0 and flush=0.
- A response with discard>0 is dropped and decrements discard.
- Flush (priority over everything):
  - Next cycle valid_ID=0 and FIFO empty.
  - discard <= outstanding_after_update - (new fire this cycle ? 1 : 0). New fetches issued in the flush cycle target the redirected PC and are kept.
  - A response in the flush cycle is dropped and counted against the old outstanding.
- Stall=1, no flush: pc_ID/inst_ID/valid_ID hold. A live response is pushed to the FIFO tail.
- Stall=0, no flush; ID loads in priority order:
  - FIFO non-empty: ID <= FIFO head (valid_ID=1), pop. A simultaneous live response is pushed; occupancy is unchanged.
  - FIFO empty and live response: ID <= {pc_resp, inst_rdata}, valid_ID=1, zero latency from data_ok to ID the next cycle.
  - Otherwise: valid_ID <= 0 (bubble); pc_ID/inst_ID hold their last values.
- FIFO is in-order, circular, with pointer wrap at BUF_DEPTH.
- Push when full cannot occur by construction. A simulation assertion fires on it and on inst_data_ok with outstanding==0.
- Reset mid-operation clears all state immediately; in-flight responses after reset are the bus's responsibility (the bus is reset together).

Optional Feature:
- Macro IF_ID_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_bubble_cycles[31:0].
  - perf_stall_cycles increments each cycle with valid_ID & IF_ID_reg_stall & !flush.
  - perf_bubble_cycles increments each cycle ID loads a bubble.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Streaming: fire every cycle, data_ok one cycle later with PCs 0x0,0x4,0x8, no stall -> pc_ID 0x0,0x4,0x8 on consecutive cycles, buf_count stays 0.
- Stall absorb: stall high 3 cycles while responses 0x10,0x14 arrive -> ID holds; buf_count=2, can_issue=0; after stall drops, ID shows 0x10 then 0x14, then buf_count=0.
- Flush with 2 outstanding: flush while outstanding=2 and no fire -> valid_ID=0 next cycle; next two responses dropped; third response (0x80) appears in ID.
- Flush with simultaneous data_ok and fire: outstanding=2 -> that response dropped; discard=1; one more response dropped; the fire's response is delivered.
- Reset mid-stall with buf_count=2: resetn low -> all outputs at reset values asynchronously; can_issue=1.
- IF_ID_PERF_EN: 4 stall cycles plus 2 bubbles -> perf_stall_cycles=4, perf_bubble_cycles=2.
